rtc_read_sequencer: RTL
=======================

RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

Interface
REQ-001 Parameter WAIT_CYC, default 4: cycles between read-enable and data capture, legal range 1..15.
REQ-002 Parameter HOLD_CYC, default 2: cycles each captured field is presented downstream, legal range 1..15.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-low reset.
- W_R, in, 1: 1 = read mode (sequencer enabled), 0 = write mode (sequencer idle).
- start, in, 1: one-cycle request to begin a read burst.
- dato_in, in, 8: packed-BCD byte from the RTC data bus.
- addr_rtc, out, 8: RTC register address.
- rd_en, out, 1: one-cycle read strobe.
- cuenta_lectura, out, 5: field code of the digit pair currently presented.
- dig_Unit, out, 4: units digit, dato_in[3:0].
- dig_Dec, out, 4: tens digit, dato_in[7:4].
- dig_valid, out, 1: high while the digits and cuenta_lectura are presented.
- bcd_err, out, 1: high with dig_valid when either nibble is greater than 9.
- busy, out, 1: burst in progress.
- done, out, 1: one-cycle pulse when a burst ends normally.

Function
REQ-004 Each burst SHALL read 9 fields in a fixed order. Each entry is index: name, addr_rtc, cuenta_lectura.
- 0: seg, 0x21, 00010
- 1: min, 0x22, 00100
- 2: hora, 0x23, 00110
- 3: dia, 0x24, 01000
- 4: mes, 0x25, 01010
- 5: an, 0x26, 01100
- 6: seg_Ti, 0x41, 01110
- 7: min_Ti, 0x42, 10000
- 8: Ho_Ti, 0x43, 00000
REQ-005 FSM states SHALL be IDLE, ADDR, WAIT, CAPTURE, PRESENT, DONE.
REQ-006 IDLE -> ADDR when start=1 and W_R=1; start in any other state SHALL be ignored.
REQ-007 ADDR SHALL last 1 cycle, drive addr_rtc from the table, and assert rd_en=1; it then goes to WAIT.
REQ-008 WAIT SHALL last exactly WAIT_CYC cycles, hold addr_rtc, and then go to CAPTURE.
REQ-009 CAPTURE SHALL last 1 cycle and register dato_in on its clock edge; it then goes to PRESENT.
REQ-010 PRESENT SHALL last exactly HOLD_CYC cycles with dig_valid=1 and stable dig_Unit, dig_Dec and cuenta_lectura.
REQ-011 At the end of PRESENT, index<8 SHALL increment the index and go to ADDR; index=8 SHALL go to DONE.
REQ-012 DONE SHALL assert done=1 for 1 cycle, clear the index to 0, and return to IDLE.
REQ-013 Per-field latency from rd_en to the first dig_valid cycle SHALL be WAIT_CYC+1 cycles; burst length SHALL be 9*(WAIT_CYC+HOLD_CYC+2)+1 cycles.
REQ-014 Outside PRESENT, cuenta_lectura SHALL be 5'b11111 (no-field code) and dig_valid SHALL be 0.
REQ-015 dig_Unit and dig_Dec SHALL hold their last captured values outside PRESENT.
REQ-016 Out-of-range nibbles (A–F) SHALL pass through unmodified, with bcd_err=1 during PRESENT for that field.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 If W_R falls in any non-IDLE state, the FSM SHALL go to IDLE on the next edge with no done pulse, the index cleared, and dig_valid and rd_en low.
REQ-019 If start and W_R fall in the same cycle as an abort, the abort SHALL take priority.
REQ-020 The index SHALL never exceed 8; the WAIT and HOLD counters SHALL be 4 bits and reset on each state entry.

Reset
REQ-021 While rst=0, the block SHALL asynchronously force the following:
- state IDLE, index 0, counters 0
- addr_rtc 0x00
- rd_en, dig_valid, bcd_err, busy, done = 0
- dig_Unit, dig_Dec = 0
- cuenta_lectura 5'b11111
REQ-022 Reset asserted mid-burst SHALL discard the burst; after release the block SHALL wait for a new start.

Structure
REQ-023 A shared package SHALL hold the following:
- FSM state enum
- 9-entry address table and 9-entry field-code table
- NO_FIELD constant 5'b11111
- default WAIT_CYC and HOLD_CYC
REQ-024 One sub-module, rtc_bcd_split, SHALL register the byte and produce dig_Unit, dig_Dec and bcd_err; all other logic stays in rtc_read_sequencer.

Verification
REQ-025 Full burst (WAIT_CYC=4, HOLD_CYC=2): W_R=1, start pulse, model returns 0x59, 0x34, 0x12, 0x27, 0x08, 0x16, 0x05, 0x10, 0x01.
- Required: 9 PRESENT windows, with index 2 showing cuenta_lectura=00110, dig_Dec=1, dig_Unit=2.
- Required: done pulses at cycle 73 after start.
REQ-026 BCD error: dato_in=0x7B on field 0 -> dig_Unit=0xB, bcd_err=1 for the 2 cycles dig_valid=1; bcd_err=0 on the other fields.
REQ-027 Abort: W_R driven to 0 during WAIT of index 4 -> next cycle busy=0, cuenta_lectura=11111, no done; next start restarts at addr_rtc=0x21.
REQ-028 Start ignored: a second start during PRESENT of index 3 -> sequence continues unchanged and exactly 1 done pulse.
REQ-029 Reset mid-burst: rst=0 during CAPTURE of index 6 -> all outputs at reset values immediately, with no clock edge needed.
REQ-030 Write mode: start with W_R=0 -> rd_en is never asserted and busy stays 0.

Source files
------------

// File: rtl/rtc_read_sequencer_pkg.sv
// Shared types and tables for the RTC read sequencer: FSM states, the nine-field
// register map, and the field codes presented alongside each digit pair.
package rtc_read_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CAPTURE,
    PRESENT,
    DONE
  } state_t;

  localparam int          DEF_WAIT_CYC = 4;
  localparam int          DEF_HOLD_CYC = 2;
  localparam logic [3:0]  LAST_IDX     = 4'd8;
  localparam logic [4:0]  NO_FIELD     = 5'b11111;

  // Entry 0 is the rightmost element: seg, min, hora, dia, mes, an, seg_Ti, min_Ti, Ho_Ti.
  localparam logic [8:0][7:0] ADDR_TBL = {
    8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };

  localparam logic [8:0][4:0] CODE_TBL = {
    5'b00000, 5'b10000, 5'b01110, 5'b01100, 5'b01010,
    5'b01000, 5'b00110, 5'b00100, 5'b00010
  };

  function automatic logic nibble_bad(input logic [3:0] n);
    return n > 4'd9;
  endfunction

endpackage

// File: rtl/rtc_bcd_split.sv
// Captures one packed-BCD byte from the RTC bus and splits it into tens/units
// digits; flags a non-decimal nibble while the pair is being presented.
module rtc_bcd_split
  import rtc_read_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       present,
  input  logic [7:0] byte_in,
  output logic [3:0] dig_unit,
  output logic [3:0] dig_dec,
  output logic       bcd_err
);

  // Digits hold their last captured value between fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_unit <= 4'd0;
      dig_dec  <= 4'd0;
    end else if (load) begin
      dig_unit <= byte_in[3:0];
      dig_dec  <= byte_in[7:4];
    end
  end

  assign bcd_err = present && (nibble_bad(dig_unit) || nibble_bad(dig_dec));

endmodule

// File: rtl/rtc_read_sequencer.sv
// Walks the nine RTC time/timer registers: address + read strobe, wait for the bus,
// capture the byte, then present the digit pair with its field code.
module rtc_read_sequencer
  import rtc_read_sequencer_pkg::*;
#(
  parameter int WAIT_CYC = DEF_WAIT_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       W_R,
  input  logic       start,
  input  logic [7:0] dato_in,
  output logic [7:0] addr_rtc,
  output logic       rd_en,
  output logic [4:0] cuenta_lectura,
  output logic [3:0] dig_Unit,
  output logic [3:0] dig_Dec,
  output logic       dig_valid,
  output logic       bcd_err,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [3:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= 4'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= (state_nxt != state || state == IDLE) ? 4'd0 : cnt + 4'd1;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE:    if (start && W_R) state_nxt = ADDR;
      ADDR:    state_nxt = WAIT;
      WAIT:    if (cnt == WAIT_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = PRESENT;
      PRESENT: begin
        if (cnt == HOLD_LAST) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = ADDR;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = 4'd0;
      end
      default: state_nxt = IDLE;
    endcase

    // Leaving read mode abandons the burst silently, overriding any other move.
    if (state != IDLE && !W_R) begin
      state_nxt = IDLE;
      idx_nxt   = 4'd0;
    end
  end

  assign busy           = (state != IDLE);
  assign rd_en          = (state == ADDR);
  assign done           = (state == DONE);
  assign dig_valid      = (state == PRESENT);
  assign cuenta_lectura = dig_valid ? CODE_TBL[idx] : NO_FIELD;
  assign addr_rtc       = (state == ADDR || state == WAIT) ? ADDR_TBL[idx] : 8'h00;

  rtc_bcd_split u_split (
    .clk      (clk),
    .rst      (rst),
    .load     (state == CAPTURE),
    .present  (dig_valid),
    .byte_in  (dato_in),
    .dig_unit (dig_Unit),
    .dig_dec  (dig_Dec),
    .bcd_err  (bcd_err)
  );

endmodule
